// File: rtl/alu_multicycle.sv
// Registered execute-stage ALU with iterative unsigned multiply/divide.
// Single-cycle ops finish in one clock; MULTU/DIVU run one bit per clock into HI/LO.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [3:0]       ALUControl,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_MFHI = 4'b1010;
  localparam logic [3:0] OP_MFLO = 4'b1011;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] wl;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH-1:0] res;
  logic             accept;
  logic             last;

  logic [WIDTH:0]   msum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH:0]   dsh;
  logic             dge;
  logic [WIDTH-1:0] ddiff;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;

  always_comb begin
    res = '0;
    case (ALUControl)
      OP_AND:  res = srcA & srcB;
      OP_OR:   res = srcA | srcB;
      OP_ADD:  res = srcA + srcB;
      OP_XOR:  res = srcA ^ srcB;
      OP_NOR:  res = ~(srcA | srcB);
      OP_SUB:  res = srcA - srcB;
      OP_SLT:  res = {{(WIDTH-1){1'b0}},
                      $signed(srcA) < $signed(srcB)};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, srcA < srcB};
      OP_MFHI: res = hi;
      OP_MFLO: res = lo;
      default: res = '0;
    endcase
  end

  // Shift-add: acc holds the running upper half, wl the multiplier/low half.
  always_comb begin
    msum   = {1'b0, acc} + {1'b0, (wl[0] ? opnd : '0)};
    mul_hi = msum[WIDTH:1];
    mul_lo = {msum[0], wl[WIDTH-1:1]};
  end

  // Restoring divide: acc is the partial remainder, wl shifts dividend out
  // and quotient bits in.
  always_comb begin
    dsh     = {acc, wl[WIDTH-1]};
    dge     = dsh >= {1'b0, opnd};
    ddiff   = dsh[WIDTH-1:0] - opnd;
    div_rem = dge ? ddiff : dsh[WIDTH-1:0];
    div_quo = {wl[WIDTH-2:0], dge};
  end

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (cnt == LAST_CNT);
  assign busy   = (state == MUL) || (state == DIV);
  assign done   = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      wl        <= '0;
      opnd      <= '0;
      ALUResult <= '0;
      Zero      <= 1'b1;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        MUL: begin
          acc <= mul_hi;
          wl  <= mul_lo;
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            hi        <= mul_hi;
            lo        <= mul_lo;
            ALUResult <= mul_lo;
            Zero      <= (mul_lo == '0);
            state     <= DONE;
          end
        end
        DIV: begin
          acc <= div_rem;
          wl  <= div_quo;
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            hi        <= div_rem;
            lo        <= div_quo;
            ALUResult <= div_quo;
            Zero      <= (div_quo == '0);
            state     <= DONE;
          end
        end
        default: begin
          if (accept) begin
            if (ALUControl == OP_MULU) begin
              acc   <= '0;
              wl    <= srcA;
              opnd  <= srcB;
              cnt   <= '0;
              state <= MUL;
            end else if (ALUControl == OP_DIVU) begin
              if (srcB == '0) begin
                // Divide by zero resolves at the sampling edge.
                hi        <= srcA;
                lo        <= '1;
                ALUResult <= '1;
                Zero      <= 1'b0;
                state     <= DONE;
              end else begin
                acc   <= '0;
                wl    <= srcA;
                opnd  <= srcB;
                cnt   <= '0;
                state <= DIV;
              end
            end else begin
              ALUResult <= res;
              Zero      <= (res == '0);
              state     <= DONE;
            end
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: logic ops, compares, MULTU/DIVU,
// back-to-back issue and asynchronous reset mid-operation.
module tb_alu_multicycle;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [3:0]  ALUControl;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;

  alu_multicycle #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .srcA(srcA),
    .srcB(srcB),
    .ALUControl(ALUControl),
    .ALUResult(ALUResult),
    .Zero(Zero),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Caller sits at a negedge; returns at the negedge after the sampling edge.
  task automatic issue(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    start      = 1'b1;
    ALUControl = op;
    srcA       = a;
    srcB       = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles until done; optionally pulses a SUB start at cycle ign.
  task automatic wait_done(output int n, output int nb, input int ign);
    n  = 1;
    nb = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy) nb++;
      if (n == ign) begin
        start      = 1'b1;
        ALUControl = 4'b0110;
        srcA       = 32'd5;
        srcB       = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    ALUControl = 4'b0000;
    srcA = '0;
    srcB = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (ALUResult !== 32'h0 || Zero !== 1'b1) begin
      failures++;
      $display("FAIL reset_res got=%h/%b exp=0/1", ALUResult, Zero);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags busy=%b done=%b exp=0/0", busy, done);
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      failures++;
      $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_logic;
    issue(4'b0000, 32'hF0F000FF, 32'h0FF00F0F);
    checks++;
    if (ALUResult !== 32'h00F0000F || Zero !== 1'b0) begin
      failures++;
      $display("FAIL and got=%h/%b exp=00f0000f/0", ALUResult, Zero);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL and_done done=%b busy=%b exp=1/0", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse got=%b exp=0", done);
    end
    issue(4'b0011, 32'hA5A5A5A5, 32'hFFFF0000);
    checks++;
    if (ALUResult !== 32'h5A5AA5A5) begin
      failures++;
      $display("FAIL xor got=%h exp=5a5aa5a5", ALUResult);
    end
    issue(4'b0100, 32'hF0F0F0F0, 32'h0000000F);
    checks++;
    if (ALUResult !== 32'h0F0F0F00) begin
      failures++;
      $display("FAIL nor got=%h exp=0f0f0f00", ALUResult);
    end
    issue(4'b0101, 32'h12345678, 32'h1);
    checks++;
    if (ALUResult !== 32'h0 || Zero !== 1'b1) begin
      failures++;
      $display("FAIL undef got=%h/%b exp=0/1", ALUResult, Zero);
    end
    issue(4'b0001, 32'h00000F00, 32'h0000000F);
    checks++;
    if (ALUResult !== 32'h00000F0F) begin
      failures++;
      $display("FAIL or got=%h exp=00000f0f", ALUResult);
    end
    issue(4'b0110, 32'd5, 32'd5);
    checks++;
    if (ALUResult !== 32'h0 || Zero !== 1'b1) begin
      failures++;
      $display("FAIL sub got=%h/%b exp=0/1", ALUResult, Zero);
    end
    @(negedge clk);
  endtask

  task automatic test_compare;
    issue(4'b0111, 32'hFFFFFFFF, 32'h1);
    checks++;
    if (ALUResult !== 32'h1 || Zero !== 1'b0) begin
      failures++;
      $display("FAIL slt got=%h/%b exp=1/0", ALUResult, Zero);
    end
    issue(4'b1111, 32'hFFFFFFFF, 32'h1);
    checks++;
    if (ALUResult !== 32'h0 || Zero !== 1'b1) begin
      failures++;
      $display("FAIL sltu got=%h/%b exp=0/1", ALUResult, Zero);
    end
    issue(4'b0010, 32'h00000010, 32'h00000022);
    checks++;
    if (ALUResult !== 32'h32) begin
      failures++;
      $display("FAIL add got=%h exp=32", ALUResult);
    end
    issue(4'b0010, 32'hFFFFFFFF, 32'h1);
    checks++;
    if (ALUResult !== 32'h0 || Zero !== 1'b1) begin
      failures++;
      $display("FAIL add_wrap got=%h/%b exp=0/1", ALUResult, Zero);
    end
    @(negedge clk);
  endtask

  task automatic test_multu;
    int n;
    int nb;
    issue(4'b1000, 32'hFFFFFFFF, 32'h2);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mul_busy got=%b exp=1", busy);
    end
    wait_done(n, nb, 5);
    checks++;
    if (n !== 33) begin
      failures++;
      $display("FAIL mul_latency got=%0d exp=33", n);
    end
    checks++;
    if (nb !== 32) begin
      failures++;
      $display("FAIL mul_busy_cycles got=%0d exp=32", nb);
    end
    checks++;
    if (hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin
      failures++;
      $display("FAIL mul_hilo got=%h/%h exp=1/fffffffe", hi, lo);
    end
    checks++;
    if (ALUResult !== 32'hFFFFFFFE || Zero !== 1'b0) begin
      failures++;
      $display("FAIL mul_res got=%h/%b exp=fffffffe/0", ALUResult, Zero);
    end
    issue(4'b1010, 32'h0, 32'h0);
    checks++;
    if (ALUResult !== 32'h1) begin
      failures++;
      $display("FAIL mfhi got=%h exp=1", ALUResult);
    end
    issue(4'b1011, 32'h0, 32'h0);
    checks++;
    if (ALUResult !== 32'hFFFFFFFE) begin
      failures++;
      $display("FAIL mflo got=%h exp=fffffffe", ALUResult);
    end
    @(negedge clk);
  endtask

  task automatic test_divu;
    int n;
    int nb;
    issue(4'b1001, 32'd100, 32'd7);
    wait_done(n, nb, 0);
    checks++;
    if (n !== 33) begin
      failures++;
      $display("FAIL div_latency got=%0d exp=33", n);
    end
    checks++;
    if (lo !== 32'd14 || hi !== 32'd2 || ALUResult !== 32'd14) begin
      failures++;
      $display("FAIL div got=lo %h hi %h res %h exp=e/2/e", lo, hi, ALUResult);
    end
    @(negedge clk);
    issue(4'b1001, 32'h1234, 32'h0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL div0_latency done=%b busy=%b exp=1/0", done, busy);
    end
    checks++;
    if (lo !== 32'hFFFFFFFF || hi !== 32'h1234) begin
      failures++;
      $display("FAIL div0 got=%h/%h exp=ffffffff/1234", lo, hi);
    end
    checks++;
    if (ALUResult !== 32'hFFFFFFFF || Zero !== 1'b0) begin
      failures++;
      $display("FAIL div0_res got=%h/%b exp=ffffffff/0", ALUResult, Zero);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int n;
    int nb;
    issue(4'b1001, 32'd100, 32'd7);
    wait_done(n, nb, 0);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_div_done got=%b exp=1", done);
    end
    issue(4'b0010, 32'd3, 32'd4);
    checks++;
    if (ALUResult !== 32'd7 || done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_add got=%h/%b exp=7/1", ALUResult, done);
    end
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      failures++;
      $display("FAIL b2b_hilo got=%h/%h exp=2/e", hi, lo);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle got=%b exp=0", done);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    int nb;
    issue(4'b1000, 32'hFFFFFFFF, 32'h2);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_flags busy=%b done=%b exp=0/0", busy, done);
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_hilo got=%h/%h exp=0/0", hi, lo);
    end
    checks++;
    if (ALUResult !== 32'h0 || Zero !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_res got=%h/%b exp=0/1", ALUResult, Zero);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(4'b1000, 32'd3, 32'd5);
    wait_done(n, nb, 0);
    checks++;
    if (n !== 33) begin
      failures++;
      $display("FAIL mul2_latency got=%0d exp=33", n);
    end
    checks++;
    if (lo !== 32'd15 || hi !== 32'd0 || ALUResult !== 32'd15) begin
      failures++;
      $display("FAIL mul2 got=lo %h hi %h res %h exp=f/0/f", lo, hi, ALUResult);
    end
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_logic();
    test_compare();
    test_multu();
    test_divu();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
